// File: rtl/mu_afeser.sv
// mu_afeser: APB-programmed serial register writer for the AD9990 AFE.
// Frames (addr in [7:0], data in [31:8]) are queued in a small FIFO and
// shifted out LSB-first on afe_sl/afe_sck/afe_sdata at a programmable rate.
module mu_afeser #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_apb_psel,
    input  logic        s_apb_penable,
    input  logic        s_apb_pwrite,
    input  logic [31:0] s_apb_paddr,
    input  logic [31:0] s_apb_pwdata,
    output logic        s_apb_pready,
    output logic [31:0] s_apb_prdata,
    output logic        afe_rst,
    output logic        afe_sl,
    output logic        afe_sck,
    output logic        afe_sdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCKH,
        SCKL,
        HOLD,
        GAP
    } state_t;

    state_t             state;
    logic               ctrl_en;
    logic               ctrl_afe_rst;
    logic               ovf;
    logic [DIV_W-1:0]   clkdiv;
    logic [DIV_W-1:0]   timer;
    logic [31:0]        shifter;
    logic [5:0]         bit_cnt;
    logic               sl;
    logic               sck;
    logic               sdata;

    logic [31:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [LVL_W-1:0]   level;

    logic [1:0]         addr;
    logic               wr_en;
    logic               wr_ctrl;
    logic               wr_stat;
    logic               wr_div;
    logic               wr_data;
    logic               flush;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               busy;
    logic [31:0]        rdata;
    logic               unused_paddr;

    assign addr         = s_apb_paddr[3:2];
    assign unused_paddr = ^{s_apb_paddr[31:4], s_apb_paddr[1:0]};
    assign wr_en        = s_apb_psel & s_apb_penable & s_apb_pwrite;
    assign wr_ctrl      = wr_en && (addr == 2'd0);
    assign wr_stat      = wr_en && (addr == 2'd1);
    assign wr_div       = wr_en && (addr == 2'd2);
    assign wr_data      = wr_en && (addr == 2'd3);
    assign flush        = wr_ctrl && s_apb_pwdata[1];
    assign empty        = (level == '0);
    assign full         = (level == LVL_W'(FIFO_DEPTH));
    assign push         = wr_data && !full;
    // A pop coinciding with FLUSH is suppressed so a flushed frame never starts.
    assign pop          = (state == IDLE) && ctrl_en && !empty && !flush;
    assign busy         = (state != IDLE) || (ctrl_en && !empty);

    assign s_apb_pready = 1'b1;
    assign afe_rst      = ctrl_afe_rst;
    assign afe_sl       = sl;
    assign afe_sck      = sck;
    assign afe_sdata    = sdata;

    // Read-data mux for the register map; unmapped bits read zero.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: begin
                rdata[0] = ctrl_en;
                rdata[2] = ctrl_afe_rst;
            end
            2'd1: begin
                rdata[0]           = busy;
                rdata[1]           = empty;
                rdata[2]           = full;
                rdata[3]           = ovf;
                rdata[8 +: LVL_W]  = level;
            end
            2'd2:    rdata[DIV_W-1:0] = clkdiv;
            default: rdata = '0;
        endcase
    end

    // Control/status registers and registered APB read data (latched in setup phase).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en      <= 1'b0;
            ctrl_afe_rst <= 1'b0;
            clkdiv       <= DIV_W'(4);
            ovf          <= 1'b0;
            s_apb_prdata <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en      <= s_apb_pwdata[0];
                ctrl_afe_rst <= s_apb_pwdata[2];
            end
            if (wr_div) begin
                clkdiv <= s_apb_pwdata[DIV_W-1:0];
            end
            if (wr_data && full) begin
                ovf <= 1'b1;
            end else if (wr_stat && s_apb_pwdata[3]) begin
                ovf <= 1'b0;
            end
            if (s_apb_psel && !s_apb_penable) begin
                s_apb_prdata <= rdata;
            end
        end
    end

    // Frame FIFO: pointers wrap naturally, level tracks occupancy 0..FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= s_apb_pwdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Shift engine: each non-idle state holds for CLKDIV+1 cycles, pins registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            shifter <= '0;
            bit_cnt <= '0;
            sl      <= 1'b1;
            sck     <= 1'b0;
            sdata   <= 1'b0;
        end else if (state == IDLE) begin
            if (pop) begin
                shifter <= mem[rptr];
                bit_cnt <= '0;
                timer   <= clkdiv;
                sl      <= 1'b0;
                sdata   <= mem[rptr][0];
                state   <= SETUP;
            end
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end else begin
            timer <= clkdiv;
            case (state)
                SETUP: begin
                    sck   <= 1'b1;
                    state <= SCKH;
                end
                SCKH: begin
                    sck     <= 1'b0;
                    shifter <= shifter >> 1;
                    sdata   <= shifter[1];
                    bit_cnt <= bit_cnt + 1'b1;
                    state   <= SCKL;
                end
                SCKL: begin
                    if (bit_cnt == 6'd32) begin
                        state <= HOLD;
                    end else begin
                        sck   <= 1'b1;
                        state <= SCKH;
                    end
                end
                HOLD: begin
                    sl    <= 1'b1;
                    state <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mu_afeser.sv
// tb_mu_afeser: directed bench for mu_afeser with a cycle-level protocol model
// and a serial receiver that reassembles frames from the AFE pins.
module tb_mu_afeser;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        afe_rst;
    logic        afe_sl;
    logic        afe_sck;
    logic        afe_sdata;

    always #5 clk = ~clk;

    mu_afeser #(.FIFO_DEPTH(DEPTH), .DIV_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_apb_psel    (psel),
        .s_apb_penable (penable),
        .s_apb_pwrite  (pwrite),
        .s_apb_paddr   (paddr),
        .s_apb_pwdata  (pwdata),
        .s_apb_pready  (pready),
        .s_apb_prdata  (prdata),
        .afe_rst       (afe_rst),
        .afe_sl        (afe_sl),
        .afe_sck       (afe_sck),
        .afe_sdata     (afe_sdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    bit          m_en, m_arst, m_ovf, m_act;
    logic [7:0]  m_div;
    int          m_k, m_r;
    logic [31:0] m_frame;
    logic [31:0] exp_prdata;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: v = {29'b0, m_arst, 1'b0, m_en};
            2'd1: v = {19'b0, 5'(mq.size()), 4'b0, m_ovf, (mq.size() == DEPTH),
                       (mq.size() == 0), (m_act || (m_en && mq.size() != 0))};
            2'd2: v = {24'b0, m_div};
            default: v = '0;
        endcase
        return v;
    endfunction

    // Pins as a function of position within the frame: k counts half-periods
    // (0 = setup, 1..64 = alternating high/low per bit, 65 = hold, 66 = gap).
    function automatic logic [2:0] exp_pins();
        int i;
        if (!m_act) return 3'b100;
        if (m_k == 0) return {2'b00, m_frame[0]};
        if (m_k <= 64) begin
            if (m_k % 2 == 1) return {2'b01, m_frame[(m_k - 1) / 2]};
            i = (m_k - 2) / 2;
            return {2'b00, (i < 31) ? m_frame[i + 1] : 1'b0};
        end
        if (m_k == 65) return 3'b000;
        return 3'b100;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit          wr, fl, was_full;
        logic [1:0]  a;
        if (!rst) begin
            mq.delete();
            m_en = 0; m_arst = 0; m_ovf = 0; m_act = 0;
            m_div = 8'd4; m_k = 0; m_r = 0; m_frame = '0;
            exp_prdata = '0;
        end else begin
            wr       = psel && penable && pwrite;
            a        = paddr[3:2];
            fl       = wr && (a == 2'd0) && pwdata[1];
            was_full = (mq.size() == DEPTH);
            if (psel && !penable) exp_prdata = m_read(a);
            if (!m_act) begin
                if (m_en && mq.size() != 0 && !fl) begin
                    m_frame = mq.pop_front();
                    m_act = 1; m_k = 0; m_r = m_div;
                end
            end else if (m_r > 0) begin
                m_r--;
            end else if (m_k == 66) begin
                m_act = 0;
            end else begin
                m_k++; m_r = m_div;
            end
            if (wr) begin
                case (a)
                    2'd0: begin
                        m_en = pwdata[0]; m_arst = pwdata[2];
                        if (pwdata[1]) mq.delete();
                    end
                    2'd1: if (pwdata[3]) m_ovf = 0;
                    2'd2: m_div = pwdata[7:0];
                    default: if (was_full) m_ovf = 1; else mq.push_back(pwdata);
                endcase
            end
        end
    end

    // Compare process: pins every cycle, read data in every read access phase.
    always @(negedge clk) begin
        check("pins", {27'b0, pready, afe_rst, afe_sl, afe_sck, afe_sdata},
              {27'b0, 1'b1, m_arst, exp_pins()});
        if (psel && penable && !pwrite) check("prdata", prdata, exp_prdata);
    end

    // ---------------- serial receiver / timing monitor ----------------
    logic [31:0] rx_q[$];
    int          sl_len_q[$];
    int          hi_q[$];
    int          lo_q[$];
    int          rises = 0;
    int          rx_bits = 0, sl_low = 0, run = 0;
    logic [31:0] rx_word = '0;
    logic        prev_sl = 1'b1, prev_sck = 1'b0;
    bit          seen_hi = 0;

    always @(negedge clk) begin
        if (afe_sck && !prev_sck) begin
            rx_bits++;
            rises++;
            rx_word = {afe_sdata, rx_word[31:1]};
        end
        if (!afe_sl) sl_low++;
        if (afe_sl && !prev_sl) begin
            sl_len_q.push_back(sl_low);
            if (rx_bits == 32) rx_q.push_back(rx_word);
            rx_bits = 0;
            sl_low = 0;
        end
        if (afe_sck != prev_sck) begin
            if (prev_sck) hi_q.push_back(run);
            else if (seen_hi) lo_q.push_back(run);
            if (afe_sck) seen_hi = 1;
            run = 1;
        end else begin
            run++;
        end
        if (afe_sl) seen_hi = 0;
        prev_sck = afe_sck;
        prev_sl  = afe_sl;
    end

    task automatic clr();
        rx_q.delete(); sl_len_q.delete(); hi_q.delete(); lo_q.delete();
        rises = 0;
    endtask

    // ---------------- APB driver (call 1 time unit after a rising edge) ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); d = prdata;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    logic [31:0] d;
    logic [31:0] F [5];
    logic [31:0] G [3];

    initial begin
        F[0] = 32'h11223344; F[1] = 32'h55667788; F[2] = 32'h99AABBCC;
        F[3] = 32'hDDEEFF00; F[4] = 32'hCAFEF00D;
        G[0] = 32'h0F0F1234; G[1] = 32'h8000_0001; G[2] = 32'h7E7E7E7E;

        // Reset
        repeat (3) @(posedge clk);
        #1 check("reset pins", {28'b0, afe_rst, afe_sl, afe_sck, afe_sdata}, 32'h4);
        @(posedge clk); #2 rst = 1;
        cycles(1);
        apb_read(32'h4, d); check("reset STATUS", d, 32'h2);
        apb_read(32'h8, d); check("reset CLKDIV", d, 32'h4);

        // AFE reset pin follows CTRL[2]
        apb_write(32'h0, 32'h4);
        check("afe_rst high", {31'b0, afe_rst}, 32'h1);
        apb_read(32'h0, d); check("CTRL readback", d, 32'h4);
        apb_write(32'h0, 32'h0);

        // Single frame at CLKDIV=0
        apb_write(32'h8, 32'h0);
        apb_write(32'h0, 32'h1);
        clr();
        apb_write(32'hC, 32'h00A5C312);
        cycles(66);
        apb_read(32'h4, d); check("STATUS busy in HOLD", d, 32'h3);
        apb_read(32'h4, d); check("STATUS idle after frame", d, 32'h2);
        cycles(4);
        check("single frame count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single frame data", rx_q[0], 32'h00A5C312);
        check("single sck rises", rises, 32);
        check("single sl count", sl_len_q.size(), 1);
        if (sl_len_q.size() > 0) check("single sl low cycles", sl_len_q[0], 66);

        // Overflow and FIFO order
        apb_write(32'h0, 32'h0);
        clr();
        for (int i = 0; i < 5; i++) apb_write(32'hC, F[i]);
        apb_read(32'h4, d); check("STATUS full+ovf", d, 32'h40C);
        apb_write(32'h4, 32'h8);
        apb_read(32'h4, d); check("STATUS ovf cleared", d, 32'h404);
        apb_write(32'h0, 32'h1);
        for (int i = 0; i < 3000 && rx_q.size() < 4; i++) @(posedge clk);
        cycles(100);
        check("ovf frame count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size()) check("ovf frame order", rx_q[i], F[i]);
        apb_read(32'h4, d); check("STATUS after drain", d, 32'h2);

        // Divider, with a mid-frame rewrite
        apb_write(32'h8, 32'h3);
        clr();
        apb_write(32'hC, 32'h000000F0);
        cycles(12);
        apb_write(32'h8, 32'h1);
        cycles(300);
        check("div hi phases", (hi_q.size() >= 3), 1);
        check("div lo phases", (lo_q.size() >= 2), 1);
        if (hi_q.size() >= 3 && lo_q.size() >= 2) begin
            check("div hi0", hi_q[0], 4);
            check("div lo0", lo_q[0], 4);
            check("div hi1 not truncated", hi_q[1], 4);
            check("div lo1 new rate", lo_q[1], 2);
            check("div hi2 new rate", hi_q[2], 2);
        end
        if (rx_q.size() > 0) check("div frame data", rx_q[0], 32'h000000F0);
        apb_write(32'h8, 32'h0);

        // FLUSH at bit 10 of frame 1
        apb_write(32'h0, 32'h0);
        clr();
        for (int i = 0; i < 3; i++) apb_write(32'hC, G[i]);
        apb_write(32'h0, 32'h1);
        cycles(20);
        apb_write(32'h0, 32'h3);
        cycles(150);
        check("flush frame count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("flush frame data", rx_q[0], G[0]);
        apb_read(32'h4, d); check("STATUS after flush", d, 32'h2);

        // EN cleared at bit 10 of frame 1
        apb_write(32'h0, 32'h0);
        clr();
        for (int i = 0; i < 3; i++) apb_write(32'hC, G[i]);
        apb_write(32'h0, 32'h1);
        cycles(20);
        apb_write(32'h0, 32'h0);
        cycles(150);
        check("en-drop frame count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("en-drop frame data", rx_q[0], G[0]);
        apb_read(32'h4, d); check("STATUS after en-drop", d, 32'h200);

        // Asynchronous reset at bit 16
        clr();
        apb_write(32'h0, 32'h1);
        cycles(33);
        @(posedge clk);
        #1 check("mid-frame sl/sck", {30'b0, afe_sl, afe_sck}, 32'h1);
        #1 rst = 0;
        #1 check("async reset pins", {28'b0, afe_rst, afe_sl, afe_sck, afe_sdata}, 32'h4);
        #20 rst = 1;
        cycles(1);
        clr();
        cycles(100);
        check("no sck after reset", rises, 0);
        check("no frame after reset", rx_q.size(), 0);
        apb_read(32'h4, d); check("STATUS after reset", d, 32'h2);
        apb_read(32'h8, d); check("CLKDIV after reset", d, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mu_afeser.md
Name: mu_afeser

Overview:
APB-programmed serial register writer for the AD9990 AFE. It replaces GPIO bit-banging of afe_sl/afe_sck/afe_sdata/afe_rst and sits on regbus as a sibling of mu_gpio. Software pushes 32-bit frames into a small FIFO: address in [7:0], data in [31:8]. A shift engine serialises each frame LSB-first with a programmable SCK rate.

Parameters:
FIFO_DEPTH, 4, frame FIFO entries (power of two, 2..16)
DIV_W, 8, width of CLKDIV register

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
s_apb_psel  in  1  APB select
s_apb_penable  in  1  APB enable
s_apb_pwrite  in  1  APB write
s_apb_paddr  in  32  APB address (only [3:2] decoded)
s_apb_pwdata  in  32  APB write data
s_apb_pready  out  1  APB ready
s_apb_prdata  out  32  APB read data
afe_rst  out  1  AFE RSTB pin level
afe_sl  out  1  serial load, active-low frame enable
afe_sck  out  1  serial clock
afe_sdata  out  1  serial data

Behaviour:
- Reset values: afe_rst=0, afe_sl=1, afe_sck=0, afe_sdata=0, s_apb_pready=1, s_apb_prdata=0. All registers and the FIFO are cleared; CLKDIV resets to 4.
- APB: zero wait state, pready tied 1. A write commits on psel&penable&pwrite. prdata is registered and valid in the access phase. Unmapped bits read 0.
- Registers:
  - 0x0 CTRL: [0] EN; [1] FLUSH (write 1, self-clears, reads 0); [2] AFE_RST drives afe_rst directly.
  - 0x4 STATUS (RO except noted): [0] BUSY; [1] EMPTY; [2] FULL; [3] OVF sticky, write 1 to clear; [8+:5] LEVEL.
  - 0x8 CLKDIV [DIV_W-1:0]: half-period = CLKDIV+1 clk cycles. CLKDIV=0 is legal and gives SCK = clk/2.
  - 0xC DATA (WO, reads 0): a write pushes pwdata. If FULL, the write is dropped and OVF is set. Push and pop in the same cycle keep LEVEL unchanged.
- Engine FSM; every state lasts exactly one half-period (timer reloads CLKDIV on entry):
  - IDLE: sl=1, sck=0. If EN and !EMPTY, pop the frame into a 32-bit shifter, set bit counter=0, go to SETUP.
  - SETUP: sl=0, sdata=shifter[0]. Go to SCKH.
  - SCKH: sck=1; the AFE samples on the rising edge. Go to SCKL.
  - SCKL: sck=0, shift right, sdata=new bit0, counter+1. If counter was 31, go to HOLD; else go to SCKH.
  - HOLD: sck=0, sl stays 0. Go to GAP.
  - GAP: sl=1. Go to IDLE.
  - One frame from pop to IDLE = (2*32+3)*(CLKDIV+1) cycles plus 1 IDLE cycle; frames are back-to-back otherwise.
- BUSY = state != IDLE, or (EN and !EMPTY).
- CLKDIV written mid-frame takes effect at the next timer reload only; the current half-period is not truncated.
- EN cleared mid-frame: the current frame completes, then the engine idles.
- FLUSH: empties the FIFO immediately. A frame already in the shifter completes. FLUSH and a DATA push cannot coincide (different addresses).
- An async reset mid-frame returns all outputs to reset values immediately; sl rises asynchronously. A partial frame is discarded.
- LEVEL counts 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset: hold rst=0 -> afe_sl=1, afe_sck=0, afe_sdata=0, afe_rst=0; STATUS=0x00000002; CLKDIV reads 4.
- Single frame: CLKDIV=0, EN=1, DATA=0x00A5C3_12 -> sl low for 66 cycles; 32 sck rising edges; sdata at rises = 0x00A5C312 LSB-first (0,1,0,0,1,0,0,0,...); sl returns high; BUSY clears 68 cycles after push.
- Overflow: EN=0, push 5 frames with FIFO_DEPTH=4 -> LEVEL=4, FULL=1, OVF=1. Write STATUS bit3=1 -> OVF=0. Set EN=1 -> exactly 4 frames shifted, first-in first-out.
- Divider: CLKDIV=3 -> each sck high and low phase lasts 4 cycles. Rewrite CLKDIV=1 mid-frame -> the in-progress half-period stays 4 cycles, subsequent ones are 2.
- Flush/EN drop: queue 3 frames, start, then FLUSH during frame 1 bit 10 -> frame 1 completes all 32 bits, no further frames, EMPTY=1. Repeat clearing EN instead -> frame 1 completes, LEVEL=2 retained.
- Async reset mid-frame at bit 16 -> afe_sl=1 with no clk edge; after release, STATUS=0x2 and no residual sck pulses.
